dm_mmio_responder: RTL and testbench
====================================

Name: dm_mmio_responder

Overview:
- Responder on the CPU data-memory port: serves loads/stores issued from M stage (w_en, address, write_data in; read_data out).
- Contains the data SRAM array plus a small MMIO window: free-running timer with compare IRQ, and a byte TX FIFO drained over a valid/ready handshake.
- Replaces the bare SRAM instance outside the core; timing matches it: writes commit at posedge, reads are combinational from address so the core's W register captures them.

Parameters:
- DM_WORDS, 8192, data array depth in 32-bit words (byte addresses 0x0000-0x7FFF); power of 2.
- TX_DEPTH, 4, TX FIFO entries; power of 2, >=2.
- TIMER_DIV, 1, timer increments once every TIMER_DIV cycles (1 = every cycle).

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  synchronous, active-high reset.
- w_en  in  4  byte write enables; w_en[i] writes write_data[8i+7:8i]; 0000 = read/idle.
- address  in  16  byte address; address[1:0] ignored (word aligned).
- write_data  in  32  store data.
- read_data  out  32  load data, combinational from address.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  consumer accepts head this cycle.
- timer_irq  out  1  equals STATUS bit0.

Behaviour:
- Decode: address[15]==0 -> RAM, word index address[14:2] (modulo DM_WORDS); address[15:8]==0xFF -> MMIO, offset address[7:0]; all else unmapped.
- RAM: byte-enabled write at posedge; not reset (contents X after power-up, preserved across rst). Read-after-write to same word sees new data next cycle.
- MMIO map: 0x00 TIMER_CNT (RW), 0x04 TIMER_CMP (RW), 0x08 STATUS (R, W1C), 0x0C TX_DATA (W-only, reads 0). Other 0xFFxx offsets unmapped. MMIO writes honour byte enables.
- Timer: prescale counter wraps at TIMER_DIV-1; on wrap cnt <= cnt+1 (32-bit wrap 0xFFFFFFFF->0). CPU write to TIMER_CNT same cycle overrides increment.
- STATUS: bit0 timer match (sticky, set in cycle cnt's registered value == cmp); bit1 FIFO full; bit2 FIFO empty; bit3 TX overflow (sticky); others 0. W1C on bits 0 and 3 (w_en[0]); set and clear in same cycle -> set wins.
- TX FIFO: push on write to TX_DATA with w_en[0]=1, byte = write_data[7:0]. Pop when tx_valid && tx_ready. First-word-fall-through: tx_data = head, valid whenever non-empty.
- Full + push, no pop -> byte dropped, bit3 set. Full + push + pop -> both accepted, stays full. Empty + push + tx_ready -> no pop that cycle (tx_valid was 0); byte visible next cycle.
- Reset values: cnt=0, cmp=0xFFFFFFFF, prescaler=0, STATUS sticky bits 0, FIFO empty (ptrs 0), tx_valid=0, tx_data=0 content irrelevant, timer_irq=0. Reset mid-drain discards FIFO contents; reset dominates any same-cycle write.
- Unmapped: writes ignored, reads return 0.

Optional Feature:
- Macro DM_ERR_EN. Defined: unmapped access (read with w_en==0 at an unmapped address, or any write) sets sticky STATUS bit4 (W1C, set wins), unmapped reads return 0xDEADBEEF. Undefined: bit4 reads 0, unmapped reads return 0.
- Qualification: reads counted only when a new address is presented is not required; bit4 sets every cycle an unmapped address is driven.

Decomposition:
- Package dm_mmio_pkg: MMIO base 0xFF, offsets OFF_TIMER_CNT/OFF_TIMER_CMP/OFF_STATUS/OFF_TX_DATA, STATUS bit indices, ERR_PATTERN 0xDEADBEEF, region-decode enum {REG_RAM, REG_MMIO, REG_NONE}.
- One sub-module: tx_fifo (parameter TX_DEPTH; push/pop/full/empty, extra-bit pointers).

Test Plan:
- Store 0x12345678 to 0x0010 w_en=1111, then 0x0000AB00 w_en=0010 -> read 0x0010 returns 0x1234AB78; read 0x8010 returns 0 (0xDEADBEEF with DM_ERR_EN, STATUS bit4=1).
- After rst write TIMER_CMP=5 (TIMER_DIV=1) -> timer_irq rises in cycle cnt reads 5, stays high; write STATUS=0x1 -> irq low next cycle; write TIMER_CNT=0xFFFFFFFF -> cnt reads 0 one cycle later.
- tx_ready=0, push 0x01..0x04 -> STATUS bit1=1; push 0x05 -> dropped, bit3=1; tx_ready=1 -> tx_data 0x01,0x02,0x03,0x04 on consecutive cycles, then tx_valid=0, bit2=1.
- FIFO full, push 0x55 with tx_ready=1 same cycle -> head popped, 0x55 at tail, bit1 stays 1, bit3 stays 0.
- Push 3 bytes, rst during drain -> next cycle tx_valid=0, STATUS=0x4, cnt=0, cmp=0xFFFFFFFF; RAM word written before rst still reads back.
- Write STATUS=0x9 in same cycle as timer match -> bit0 remains 1, bit3 cleared.

Source files
------------

// File: rtl/dm_mmio_pkg.sv
// Shared constants, region decode and byte-merge helper for the data-memory responder.
package dm_mmio_pkg;

  localparam logic [7:0] MMIO_BASE     = 8'hFF;
  localparam logic [7:0] OFF_TIMER_CNT = 8'h00;
  localparam logic [7:0] OFF_TIMER_CMP = 8'h04;
  localparam logic [7:0] OFF_STATUS    = 8'h08;
  localparam logic [7:0] OFF_TX_DATA   = 8'h0C;

  localparam int unsigned ST_MATCH = 0;
  localparam int unsigned ST_FULL  = 1;
  localparam int unsigned ST_EMPTY = 2;
  localparam int unsigned ST_OVF   = 3;
  localparam int unsigned ST_ERR   = 4;

  localparam logic [31:0] ERR_PATTERN = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_NONE
  } region_e;

  function automatic region_e decode_region(input logic [15:0] addr);
    if (!addr[15])                    return REG_RAM;
    else if (addr[15:8] == MMIO_BASE) return REG_MMIO;
    else                              return REG_NONE;
  endfunction

  // Replace the enabled bytes of old_val with the matching bytes of new_val.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dm_mmio_tx_fifo.sv
// Byte FIFO with first-word-fall-through head; extra-bit pointers separate full from empty.
module tx_fifo #(
  parameter int unsigned TX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head_c,
  output logic       full_c,
  output logic       empty_c
);

  localparam int unsigned PW = $clog2(TX_DEPTH);

  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  logic [7:0]  mem [TX_DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head_c  = mem[rd_ptr[PW-1:0]];

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign do_push = push && (!full_c || pop);
  assign do_pop  = pop && !empty_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(TX_DEPTH); i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[PW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + (PW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

endmodule

// File: rtl/dm_mmio_responder.sv
// Data-memory port responder: SRAM array plus timer/STATUS/TX-FIFO MMIO window at 0xFFxx.
// Optional DM_ERR_EN: sticky STATUS bit4 on unmapped access, unmapped reads return 0xDEADBEEF.
module dm_mmio_responder
  import dm_mmio_pkg::*;
#(
  parameter int unsigned DM_WORDS  = 8192,
  parameter int unsigned TX_DEPTH  = 4,
  parameter int unsigned TIMER_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  w_en,
  input  logic [15:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        timer_irq
);

  localparam int unsigned AW  = $clog2(DM_WORDS);
  localparam int unsigned PSW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

  region_e     region;
  logic [7:0]  offset;
  logic        wr;
  logic [AW-1:0] ram_idx;
  logic [31:0] ram [DM_WORDS];

  logic [31:0]    cnt_q, cnt_d;
  logic [31:0]    cmp_q, cmp_d;
  logic [PSW-1:0] pre_q, pre_d;
  logic           match_q, match_d;
  logic           ovf_q, ovf_d;
  logic           err_bit;
  logic           match_now;

  logic wr_cnt, wr_cmp, wr_status, push, pop;
  logic fifo_full, fifo_empty;
  logic mmio_mapped;
  logic [31:0] status_rd;
  logic [31:0] unmapped_val;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^address[1:0];

  assign region  = decode_region(address);
  assign offset  = address[7:0];
  assign wr      = |w_en;
  assign ram_idx = AW'(address[14:2]);

  assign mmio_mapped = (offset == OFF_TIMER_CNT) || (offset == OFF_TIMER_CMP) ||
                       (offset == OFF_STATUS)    || (offset == OFF_TX_DATA);

  assign wr_cnt    = wr && (region == REG_MMIO) && (offset == OFF_TIMER_CNT);
  assign wr_cmp    = wr && (region == REG_MMIO) && (offset == OFF_TIMER_CMP);
  assign wr_status = w_en[0] && (region == REG_MMIO) && (offset == OFF_STATUS);
  assign push      = w_en[0] && (region == REG_MMIO) && (offset == OFF_TX_DATA);
  assign pop       = tx_valid && tx_ready;

  // RAM is deliberately not reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst && wr && (region == REG_RAM)) begin
      for (int i = 0; i < 4; i++) begin
        if (w_en[i]) ram[ram_idx][8*i +: 8] <= write_data[8*i +: 8];
      end
    end
  end

  tx_fifo #(.TX_DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (write_data[7:0]),
    .pop       (pop),
    .head_c    (tx_data),
    .full_c    (fifo_full),
    .empty_c   (fifo_empty)
  );

  assign tx_valid  = !fifo_empty;
  assign match_now = (cnt_q == cmp_q);
  // Match is visible in the very cycle the registered count equals the compare value.
  assign timer_irq = match_q | match_now;

  // Timer, compare and sticky status next-state; set beats W1C.
  always_comb begin
    cnt_d   = cnt_q;
    cmp_d   = cmp_q;
    pre_d   = pre_q;
    match_d = match_q;
    ovf_d   = ovf_q;

    if (pre_q == PSW'(TIMER_DIV - 1)) begin
      pre_d = '0;
      cnt_d = cnt_q + 32'd1;
    end else begin
      pre_d = pre_q + PSW'(1);
    end
    if (wr_cnt) cnt_d = merge_bytes(cnt_q, write_data, w_en);
    if (wr_cmp) cmp_d = merge_bytes(cmp_q, write_data, w_en);

    if (wr_status && write_data[ST_MATCH]) match_d = 1'b0;
    if (match_now)                         match_d = 1'b1;
    if (wr_status && write_data[ST_OVF])   ovf_d   = 1'b0;
    if (push && fifo_full && !pop)         ovf_d   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      cmp_q   <= '1;
      pre_q   <= '0;
      match_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      pre_q   <= pre_d;
      match_q <= match_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef DM_ERR_EN
  logic err_q, err_d;
  logic unmapped;

  assign unmapped = (region == REG_NONE) || ((region == REG_MMIO) && !mmio_mapped);

  always_comb begin
    err_d = err_q;
    if (wr_status && write_data[ST_ERR]) err_d = 1'b0;
    if (unmapped)                        err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err_bit      = err_q;
  assign unmapped_val = ERR_PATTERN;
`else
  assign err_bit      = 1'b0;
  assign unmapped_val = 32'h0;
`endif

  always_comb begin
    status_rd           = '0;
    status_rd[ST_MATCH] = match_q | match_now;
    status_rd[ST_FULL]  = fifo_full;
    status_rd[ST_EMPTY] = fifo_empty;
    status_rd[ST_OVF]   = ovf_q;
    status_rd[ST_ERR]   = err_bit;
  end

  // Combinational load path, captured by the core's W register.
  always_comb begin
    read_data = unmapped_val;
    case (region)
      REG_RAM:  read_data = ram[ram_idx];
      REG_MMIO: begin
        case (offset)
          OFF_TIMER_CNT: read_data = cnt_q;
          OFF_TIMER_CMP: read_data = cmp_q;
          OFF_STATUS:    read_data = status_rd;
          OFF_TX_DATA:   read_data = 32'h0;
          default:       read_data = unmapped_val;
        endcase
      end
      default:  read_data = unmapped_val;
    endcase
  end

endmodule

// File: tb/tb_dm_mmio_responder.sv
// Directed bench for dm_mmio_responder: RAM vector table plus timer and TX-FIFO sequences.
module tb_dm_mmio_responder;

  logic        clk;
  logic        rst;
  logic [3:0]  w_en;
  logic [15:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        timer_irq;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef DM_ERR_EN
  localparam logic [31:0] UM     = 32'hDEADBEEF;
  localparam logic [31:0] ST_ERR = 32'h10;
`else
  localparam logic [31:0] UM     = 32'h0;
  localparam logic [31:0] ST_ERR = 32'h0;
`endif

  dm_mmio_responder dut (
    .clk        (clk),
    .rst        (rst),
    .w_en       (w_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .timer_irq  (timer_irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic [3:0]  be;
    logic [15:0] wa;
    logic [31:0] wd;
    logic [15:0] ra;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_check(input string name, input logic [15:0] a, input logic [31:0] exp);
    address = a;
    w_en    = 4'h0;
    #1;
    check(name, read_data, exp);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    address    = a;
    write_data = d;
    w_en       = be;
    step();
    w_en = 4'h0;
  endtask

  task automatic push(input logic [7:0] b);
    wr(16'hFF0C, {24'h0, b}, 4'b0001);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    w_en    = 4'h0;
    address = 16'h0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; w_en = 4'h0; address = 16'h0; write_data = 32'h0; tx_ready = 1'b0;

    vecs[0] = '{4'hF, 16'h0010, 32'h12345678, 16'h0010, 32'h12345678};
    vecs[1] = '{4'h2, 16'h0010, 32'h0000AB00, 16'h0010, 32'h1234AB78};
    vecs[2] = '{4'h0, 16'h0000, 32'h0,        16'h8010, UM};
    vecs[3] = '{4'h8, 16'h0010, 32'hCD000000, 16'h0010, 32'hCD34AB78};
    vecs[4] = '{4'h1, 16'h0013, 32'h000000EE, 16'h0010, 32'hCD34ABEE};
    vecs[5] = '{4'hF, 16'h7FFC, 32'hA5A5A5A5, 16'h7FFC, 32'hA5A5A5A5};
    vecs[6] = '{4'hF, 16'h8000, 32'h11111111, 16'h8000, UM};
    vecs[7] = '{4'h0, 16'h0000, 32'h0,        16'hFF10, UM};
    vecs[8] = '{4'h0, 16'h0000, 32'h0,        16'hFF0C, 32'h0};
    vecs[9] = '{4'hF, 16'h0000, 32'h0BADF00D, 16'h0010, 32'hCD34ABEE};

    do_reset();
    check("rst_irq", {31'h0, timer_irq}, 32'h0);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    rd_check("rst_cnt", 16'hFF00, 32'h0);
    rd_check("rst_cmp", 16'hFF04, 32'hFFFFFFFF);
    rd_check("rst_status", 16'hFF08, 32'h4);

    // RAM and decode vectors
    for (int i = 0; i < 10; i++) begin
      wr(vecs[i].wa, vecs[i].wd, vecs[i].be);
      rd_check($sformatf("ram_vec%0d", i), vecs[i].ra, vecs[i].exp);
    end
    rd_check("ram_word0", 16'h0000, 32'h0BADF00D);
    rd_check("status_err", 16'hFF08, 32'h4 | ST_ERR);

    // Timer compare, sticky irq, W1C, counter wrap
    do_reset();
    wr(16'hFF04, 32'd5, 4'hF);
    check("tmr_irq_c1", {31'h0, timer_irq}, 32'h0);
    repeat (3) step();
    rd_check("tmr_cnt4", 16'hFF00, 32'd4);
    check("tmr_irq_c4", {31'h0, timer_irq}, 32'h0);
    step();
    rd_check("tmr_cnt5", 16'hFF00, 32'd5);
    check("tmr_irq_c5", {31'h0, timer_irq}, 32'h1);
    step();
    check("tmr_irq_sticky", {31'h0, timer_irq}, 32'h1);
    wr(16'hFF08, 32'h1, 4'b0001);
    check("tmr_irq_w1c", {31'h0, timer_irq}, 32'h0);
    rd_check("tmr_cnt7", 16'hFF00, 32'd7);
    wr(16'hFF00, 32'hFFFFFFFF, 4'hF);
    rd_check("tmr_cnt_max", 16'hFF00, 32'hFFFFFFFF);
    step();
    rd_check("tmr_cnt_wrap", 16'hFF00, 32'h0);

    // FIFO fill, overflow, drain
    do_reset();
    for (int k = 1; k <= 4; k++) push(8'(k));
    rd_check("fifo_full_st", 16'hFF08, 32'h2);
    check("fifo_valid", {31'h0, tx_valid}, 32'h1);
    check("fifo_head", {24'h0, tx_data}, 32'h01);
    push(8'h05);
    rd_check("fifo_ovf_st", 16'hFF08, 32'hA);
    tx_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("drain_data%0d", k), {24'h0, tx_data}, 32'(k));
      step();
    end
    check("drain_empty_valid", {31'h0, tx_valid}, 32'h0);
    rd_check("drain_status", 16'hFF08, 32'hC);
    tx_ready = 1'b0;

    // W1C of match and overflow in the match cycle: set wins for bit0
    wr(16'hFF04, 32'd100, 4'hF);
    wr(16'hFF00, 32'd99, 4'hF);
    step();
    rd_check("match_cycle_st", 16'hFF08, 32'hD);
    wr(16'hFF08, 32'h9, 4'b0001);
    rd_check("match_setwins_st", 16'hFF08, 32'h5);
    check("match_irq", {31'h0, timer_irq}, 32'h1);
    wr(16'hFF08, 32'h1, 4'b0001);
    rd_check("match_clr_st", 16'hFF08, 32'h4);

    // Full FIFO with simultaneous push and pop
    for (int k = 1; k <= 4; k++) push(8'(k * 17));
    rd_check("pp_full_st", 16'hFF08, 32'h2);
    tx_ready = 1'b1;
    push(8'h55);
    check("pp_head", {24'h0, tx_data}, 32'h22);
    rd_check("pp_status", 16'hFF08, 32'h2);
    step();
    check("pp_d33", {24'h0, tx_data}, 32'h33);
    step();
    check("pp_d44", {24'h0, tx_data}, 32'h44);
    step();
    check("pp_d55", {24'h0, tx_data}, 32'h55);
    step();
    check("pp_empty", {31'h0, tx_valid}, 32'h0);

    // Push into empty FIFO while ready: no pop that cycle
    push(8'h66);
    check("ep_valid", {31'h0, tx_valid}, 32'h1);
    check("ep_data", {24'h0, tx_data}, 32'h66);
    tx_ready = 1'b0;

    // Reset during drain, with a competing write
    wr(16'h0040, 32'hCAFEF00D, 4'hF);
    push(8'h77);
    push(8'h88);
    tx_ready = 1'b1;
    step();
    check("rd_head77", {24'h0, tx_data}, 32'h77);
    rst = 1'b1; address = 16'hFF04; write_data = 32'd7; w_en = 4'hF;
    step();
    rst = 1'b0; w_en = 4'h0; tx_ready = 1'b0;
    check("rst_drain_valid", {31'h0, tx_valid}, 32'h0);
    rd_check("rst_drain_cnt", 16'hFF00, 32'h0);
    rd_check("rst_drain_cmp", 16'hFF04, 32'hFFFFFFFF);
    rd_check("rst_drain_st", 16'hFF08, 32'h4);
    rd_check("rst_ram_kept", 16'h0040, 32'hCAFEF00D);
    check("rst_drain_irq", {31'h0, timer_irq}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
